// File: rtl/addsub_pkg.sv
// Shared constants and helpers for the pipelined add/subtract datapath.
// Optional status flags are enabled with the ADDSUB_FLAGS_EN macro.
package addsub_pkg;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   function automatic int num_stages(input int width, input int chunk);
      return width / chunk;
   endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub.
// zero/negative exist only when ADDSUB_FLAGS_EN is defined.
interface pipelined_addsub_if #(parameter int WIDTH = 16);

   logic             in_valid, in_ready;
   logic [WIDTH-1:0] a, b;
   logic             carry_in, sub;
   logic             out_valid, out_ready;
   logic [WIDTH-1:0] sum;
   logic             carry_out, overflow;
`ifdef ADDSUB_FLAGS_EN
   logic             zero, negative;
`endif

   modport master (
      output in_valid, a, b, carry_in, sub, out_ready,
`ifdef ADDSUB_FLAGS_EN
      input  zero, negative,
`endif
      input  in_ready, out_valid, sum, carry_out, overflow
   );

   modport slave (
      input  in_valid, a, b, carry_in, sub, out_ready,
`ifdef ADDSUB_FLAGS_EN
      output zero, negative,
`endif
      output in_ready, out_valid, sum, carry_out, overflow
   );

endinterface

// File: rtl/addsub_stage.sv
// One CHUNK-bit ripple slice with registered sum, carry and valid.
// With ADDSUB_FLAGS_EN a running zero flag is accumulated per slice.
module addsub_stage
   import addsub_pkg::*;
#(
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_adv,
   input  logic             i_vld,
   input  logic [CHUNK-1:0] i_a,
   input  logic [CHUNK-1:0] i_b,
   input  logic             i_c,
`ifdef ADDSUB_FLAGS_EN
   input  logic             i_zero,
   output logic             o_zero,
`endif
   output logic             o_vld,
   output logic [CHUNK-1:0] o_sum,
   output logic             o_c,
   output logic             o_cmsb
);

   logic [CHUNK:0]   w_c;
   logic [CHUNK-1:0] w_s;
   logic             r_vld, r_c, r_cmsb;
   logic [CHUNK-1:0] r_sum;

   assign w_c[0] = i_c;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      fulladder u_fa (
         .i_a(i_a[i]), .i_b(i_b[i]), .i_c(w_c[i]),
         .o_s(w_s[i]), .o_c(w_c[i+1])
      );
   end

   // Data only loads on valid slots so bubbles leave the last result intact.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld  <= 1'b0;
         r_sum  <= '0;
         r_c    <= 1'b0;
         r_cmsb <= 1'b0;
      end else if (i_adv) begin
         r_vld <= i_vld;
         if (i_vld) begin
            r_sum  <= w_s;
            r_c    <= w_c[CHUNK];
            r_cmsb <= w_c[CHUNK-1];
         end
      end
   end

`ifdef ADDSUB_FLAGS_EN
   logic r_zero;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                r_zero <= 1'b0;
      else if (i_adv && i_vld)   r_zero <= i_zero & (w_s == '0);
   end
   assign o_zero = r_zero;
`endif

   assign o_vld  = r_vld;
   assign o_sum  = r_sum;
   assign o_c    = r_c;
   assign o_cmsb = r_cmsb;

endmodule

// File: rtl/fulladder.sv
// Single-bit full adder used as the ripple cell of each stage.
module fulladder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_s,
   output logic o_c
);

   assign o_s = i_a ^ i_b ^ i_c;
   assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

// File: rtl/pipelined_addsub.sv
// WIDTH-bit add/subtract pipelined as CHUNK-bit ripple slices, one per stage.
// Define ADDSUB_FLAGS_EN to add registered zero/negative outputs.
module pipelined_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input logic               clk,
   input logic               rst_n,
   pipelined_addsub_if.slave bus
);

   localparam int STAGES = num_stages(WIDTH, CHUNK);

   if (WIDTH % CHUNK != 0) begin : g_bad_cfg
      $error("pipelined_addsub: WIDTH must be a multiple of CHUNK");
   end

   logic                          w_adv, w_c0, w_cmsb_top;
   logic [WIDTH-1:0]              w_b;
   logic [STAGES-1:0]             w_vld, w_c;
   logic [STAGES-1:0][CHUNK-1:0]  w_sum, w_res;
`ifdef ADDSUB_FLAGS_EN
   logic [STAGES-1:0]             w_zero;
`endif

   // One global enable: the whole pipe freezes when the output is held.
   assign w_adv        = !w_vld[STAGES-1] | bus.out_ready;
   assign bus.in_ready = w_adv;
   assign w_b          = (bus.sub == MODE_SUB) ? ~bus.b : bus.b;
   assign w_c0         = (bus.sub == MODE_SUB) ? 1'b1 : bus.carry_in;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [CHUNK-1:0] w_opa, w_opb;
      logic             w_cin, w_vin, w_cmsb;
`ifdef ADDSUB_FLAGS_EN
      logic             w_zin;
`endif

      if (k == 0) begin : g_head
         assign w_opa = bus.a[CHUNK-1:0];
         assign w_opb = w_b[CHUNK-1:0];
         assign w_cin = w_c0;
         assign w_vin = bus.in_valid;
`ifdef ADDSUB_FLAGS_EN
         assign w_zin = 1'b1;
`endif
      end else begin : g_skew
         // k-deep delay line so this chunk meets the carry from stage k-1.
         logic [k-1:0][CHUNK-1:0] r_a, r_b;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_a <= '0;
               r_b <= '0;
            end else if (w_adv) begin
               r_a[0] <= bus.a[k*CHUNK +: CHUNK];
               r_b[0] <= w_b[k*CHUNK +: CHUNK];
               for (int d = 1; d < k; d++) begin
                  r_a[d] <= r_a[d-1];
                  r_b[d] <= r_b[d-1];
               end
            end
         end
         assign w_opa = r_a[k-1];
         assign w_opb = r_b[k-1];
         assign w_cin = w_c[k-1];
         assign w_vin = w_vld[k-1];
`ifdef ADDSUB_FLAGS_EN
         assign w_zin = w_zero[k-1];
`endif
      end

      addsub_stage #(.CHUNK(CHUNK)) u_stage (
         .clk(clk), .rst_n(rst_n), .i_adv(w_adv), .i_vld(w_vin),
         .i_a(w_opa), .i_b(w_opb), .i_c(w_cin),
`ifdef ADDSUB_FLAGS_EN
         .i_zero(w_zin), .o_zero(w_zero[k]),
`endif
         .o_vld(w_vld[k]), .o_sum(w_sum[k]), .o_c(w_c[k]), .o_cmsb(w_cmsb)
      );

      if (k == STAGES-1) begin : g_top
         assign w_cmsb_top = w_cmsb;
         assign w_res[k]   = w_sum[k];
      end else begin : g_low
         localparam int L = STAGES-1-k;
         logic                    w_cmsb_unused;
         logic [L-1:0][CHUNK-1:0] r_dsk;
         assign w_cmsb_unused = w_cmsb;
         // Each slot moves only with the valid bit it is aligned to.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_dsk <= '0;
            end else if (w_adv) begin
               if (w_vld[k]) r_dsk[0] <= w_sum[k];
               for (int d = 1; d < L; d++)
                  if (w_vld[k+d]) r_dsk[d] <= r_dsk[d-1];
            end
         end
         assign w_res[k] = r_dsk[L-1];
      end
   end

   assign bus.out_valid = w_vld[STAGES-1];
   assign bus.sum       = w_res;
   assign bus.carry_out = w_c[STAGES-1];
   assign bus.overflow  = w_cmsb_top ^ w_c[STAGES-1];
`ifdef ADDSUB_FLAGS_EN
   assign bus.zero      = w_zero[STAGES-1];
   assign bus.negative  = w_res[STAGES-1][CHUNK-1];
`endif

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub (WIDTH=16, CHUNK=4): latency, wrap, stall, reset.
// Flag checks are compiled in when ADDSUB_FLAGS_EN is defined.
module tb_pipelined_addsub;

   localparam int W = 16;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         co, ov, z, n;
   } res_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   n_chk = 0, n_pass = 0, cyc = 0, n_got = 0;
   int   cons_cyc [$];
   res_t q [$];
   res_t sb_e;

   pipelined_addsub_if #(.WIDTH(W)) bus ();
   pipelined_addsub #(.WIDTH(W), .CHUNK(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Plain full-width arithmetic; carry into MSB from a separate 15-bit add.
   function automatic res_t model(input logic [W-1:0] a, b, input logic cin, sb);
      res_t         r;
      logic [W-1:0] bb;
      logic         c0;
      logic [W:0]   f;
      logic [W-1:0] lo;
      bb   = sb ? ~b : b;
      c0   = sb ? 1'b1 : cin;
      f    = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c0};
      lo   = {1'b0, a[W-2:0]} + {1'b0, bb[W-2:0]} + {{(W-1){1'b0}}, c0};
      r.sum = f[W-1:0];
      r.co  = f[W];
      r.ov  = lo[W-1] ^ f[W];
      r.z   = (f[W-1:0] == '0);
      r.n   = f[W-1];
      return r;
   endfunction

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            n_got++;
            cons_cyc.push_back(cyc);
            if (q.size() == 0) begin
               chk("unexpected_result", {31'b0, bus.out_valid}, 32'd0);
            end else begin
               sb_e = q.pop_front();
               chk("sb_sum", {16'b0, bus.sum}, {16'b0, sb_e.sum});
               chk("sb_carry", {31'b0, bus.carry_out}, {31'b0, sb_e.co});
               chk("sb_ovf", {31'b0, bus.overflow}, {31'b0, sb_e.ov});
`ifdef ADDSUB_FLAGS_EN
               chk("sb_zero", {31'b0, bus.zero}, {31'b0, sb_e.z});
               chk("sb_neg", {31'b0, bus.negative}, {31'b0, sb_e.n});
`endif
            end
         end
         if (bus.in_valid && bus.in_ready)
            q.push_back(model(bus.a, bus.b, bus.carry_in, bus.sub));
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic drive(input logic [W-1:0] a, b, input logic cin, sb);
      bus.a = a; bus.b = b; bus.carry_in = cin; bus.sub = sb; bus.in_valid = 1'b1;
   endtask

   task automatic send(input logic [W-1:0] a, b, input logic cin, sb);
      int   t;
      logic acc;
      t = 0;
      drive(a, b, cin, sb);
      do begin
         @(negedge clk); acc = bus.in_ready;
         @(posedge clk); #1; t++;
      end while (!acc && t < 50);
      if (!acc) chk("send_timeout", {31'b0, acc}, 32'd1);
      bus.in_valid = 1'b0;
   endtask

   task automatic op_lat(input string tag, input logic [W-1:0] a, b, input logic cin, sb,
                         input logic [W-1:0] es, input logic eco, eov);
      int lat;
      lat = 1;
      send(a, b, cin, sb);
      while (!bus.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      chk({tag, "_lat"}, lat, 32'd4);
      chk({tag, "_sum"}, {16'b0, bus.sum}, {16'b0, es});
      chk({tag, "_carry"}, {31'b0, bus.carry_out}, {31'b0, eco});
      chk({tag, "_ovf"}, {31'b0, bus.overflow}, {31'b0, eov});
   endtask

   task automatic drain;
      int t;
      t = 0;
      while ((q.size() != 0 || bus.out_valid) && t < 100) begin @(posedge clk); #1; t++; end
      chk("drain_empty", q.size(), 32'd0);
   endtask

   initial begin
      int base, seen;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.carry_in = 1'b0;
      bus.sub = 1'b0; bus.out_ready = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst_sum", {16'b0, bus.sum}, 32'd0);
      chk("rst_carry", {31'b0, bus.carry_out}, 32'd0);
      chk("rst_ovf", {31'b0, bus.overflow}, 32'd0);
      chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

      op_lat("add",       16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);
      op_lat("sub_borrow",16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      op_lat("sub_cin_ign",16'h0003,16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      op_lat("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      op_lat("wrap_u",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      op_lat("wrap_s",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
`ifdef ADDSUB_FLAGS_EN
      chk("wrap_s_neg", {31'b0, bus.negative}, 32'd1);
      chk("wrap_s_zero", {31'b0, bus.zero}, 32'd0);
`endif
      tick(3);
      chk("hold_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("hold_sum", {16'b0, bus.sum}, 32'h8000);
      chk("hold_ovf", {31'b0, bus.overflow}, 32'd1);
`ifdef ADDSUB_FLAGS_EN
      op_lat("flags",     16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      chk("flags_zero", {31'b0, bus.zero}, 32'd1);
      chk("flags_neg", {31'b0, bus.negative}, 32'd0);
`endif
      drain();

      // back-to-back stream
      base = n_got;
      for (int i = 0; i < 20; i++)
         send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drain();
      chk("stream_count", n_got - base, 32'd20);
      if (n_got - base >= 20)
         chk("stream_rate", cons_cyc[base+19] - cons_cyc[base], 32'd19);

      // backpressure
      base = n_got;
      bus.out_ready = 1'b0;
      send(16'h1111, 16'h2222, 1'b0, 1'b0);
      send(16'h0100, 16'h0001, 1'b0, 1'b1);
      send(16'hA5A5, 16'h5A5A, 1'b1, 1'b0);
      send(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
      drive(16'h0F0F, 16'h0101, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
         chk("bp_valid", {31'b0, bus.out_valid}, 32'd1);
         chk("bp_sum", {16'b0, bus.sum}, 32'h3333);
         tick(1);
      end
      bus.out_ready = 1'b1;
      send(16'h0F0F, 16'h0101, 1'b0, 1'b1);
      drain();
      chk("bp_count", n_got - base, 32'd5);

      // asynchronous reset with three ops in flight
      base = n_got;
      send(16'h0001, 16'h0002, 1'b0, 1'b0);
      send(16'h4444, 16'h1111, 1'b0, 1'b1);
      send(16'hC000, 16'h4000, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("mid_rst_sum", {16'b0, bus.sum}, 32'd0);
      chk("mid_rst_carry", {31'b0, bus.carry_out}, 32'd0);
      chk("mid_rst_ovf", {31'b0, bus.overflow}, 32'd0);
      #2 rst_n = 1'b1;
      seen = 0;
      repeat (8) begin @(posedge clk); #1; if (bus.out_valid) seen++; end
      chk("rst_no_ghost", seen, 32'd0);
      chk("rst_no_result", n_got - base, 32'd0);
      op_lat("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
